// File: rtl/vga_pkg.sv
// Shared VGA timing constants, colour constants and small helpers for the frame reader.
package vga_pkg;

    localparam int CNT_W = 32'd10;

    localparam int H_TOTAL      = 32'd800;
    localparam int V_TOTAL      = 32'd525;
    localparam int H_SYNC_START = 32'd656;
    localparam int H_SYNC_END   = 32'd751;
    localparam int V_SYNC_START = 32'd490;
    localparam int V_SYNC_END   = 32'd491;

    typedef logic [11:0] rgb_t;

    localparam rgb_t SAND_RGB   = 12'hFC8;
    localparam rgb_t EMPTY_RGB  = 12'h000;
    localparam rgb_t CURSOR_RGB = 12'hF00;

    function automatic logic in_window(
        input logic [CNT_W-1:0] pos,
        input logic [CNT_W-1:0] first,
        input logic [CNT_W-1:0] last
    );
        return (pos >= first) && (pos <= last);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-enable divider, raster counters, active-area/vblank decode and frame wrap pulses.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int ACTIVE_COLUMNS = 640,
    parameter int ACTIVE_ROWS    = 480,
    parameter int H_TOTAL_P      = 800,
    parameter int V_TOTAL_P      = 525,
    parameter int PIXEL_DIV      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             tick,
    output logic [CNT_W-1:0] h_count,
    output logic [CNT_W-1:0] v_count,
    output logic             active,
    output logic             vblank,
    output logic             frame_wrap,
    output logic             wrap_pulse
);

    localparam int               DIV_W    = (PIXEL_DIV > 1) ? $clog2(PIXEL_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIXEL_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(32'd1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL_P - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL_P - 1);
    localparam logic [CNT_W-1:0] COL_END  = CNT_W'(ACTIVE_COLUMNS);
    localparam logic [CNT_W-1:0] ROW_END  = CNT_W'(ACTIVE_ROWS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    logic [DIV_W-1:0] div_r;
    logic [CNT_W-1:0] h_r;
    logic [CNT_W-1:0] v_r;
    logic             vblank_r;
    logic             wrap_r;
    logic [CNT_W-1:0] h_next_s;
    logic [CNT_W-1:0] v_next_s;
    logic             tick_s;
    logic             wrap_s;

    // Next raster position: counters only move on the pixel tick.
    always_comb begin
        tick_s   = (div_r == DIV_LAST);
        wrap_s   = tick_s && (h_r == H_LAST) && (v_r == V_LAST);
        h_next_s = h_r;
        v_next_s = v_r;
        if (tick_s) begin
            if (h_r == H_LAST) begin
                h_next_s = {CNT_W{1'b0}};
                if (v_r == V_LAST) begin
                    v_next_s = {CNT_W{1'b0}};
                end else begin
                    v_next_s = v_r + CNT_ONE;
                end
            end else begin
                h_next_s = h_r + CNT_ONE;
            end
        end else begin
            h_next_s = h_r;
        end
    end

    // Divider, counters, vblank level and the registered wrap marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r    <= {DIV_W{1'b0}};
            h_r      <= {CNT_W{1'b0}};
            v_r      <= {CNT_W{1'b0}};
            vblank_r <= 1'b0;
            wrap_r   <= 1'b0;
        end else begin
            if (tick_s) begin
                div_r <= {DIV_W{1'b0}};
            end else begin
                div_r <= div_r + DIV_ONE;
            end
            h_r      <= h_next_s;
            v_r      <= v_next_s;
            vblank_r <= (v_next_s >= ROW_END);
            wrap_r   <= wrap_s;
        end
    end

    assign tick       = tick_s;
    assign h_count    = h_r;
    assign v_count    = v_r;
    assign active     = (h_r < COL_END) && (v_r < ROW_END);
    assign vblank     = vblank_r;
    assign frame_wrap = wrap_s;
    assign wrap_pulse = wrap_r;

endmodule

// File: rtl/vga_frame_reader.sv
// VGA frame reader: raster VRAM addressing, one-pixel-delayed sync/colour stage, frame_start/vblank.
// Optional cursor overlay is compiled in with `define CURSOR_OVERLAY_EN.
module vga_frame_reader
    import vga_pkg::*;
#(
    parameter int ACTIVE_COLUMNS = 640,
    parameter int ACTIVE_ROWS    = 480,
    parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
    parameter int DATA_WIDTH     = 1,
    parameter int H_FRONT        = 16,
    parameter int H_SYNC         = 96,
    parameter int H_BACK         = 48,
    parameter int V_FRONT        = 10,
    parameter int V_SYNC         = 2,
    parameter int V_BACK         = 33,
    parameter int PIXEL_DIV      = 4,
    parameter int READ_LATENCY   = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic [DATA_WIDTH-1:0] vram_read_data_i,
    input  logic [9:0]            cursor_x_i,
    input  logic [9:0]            cursor_y_i,
    output logic [ADDR_WIDTH-1:0] vram_read_address_o,
    output logic                  hsync_o,
    output logic                  vsync_o,
    output logic                  video_on_o,
    output logic [11:0]           rgb_o,
    output logic                  frame_start_o,
    output logic                  vblank_o
);

    localparam int H_TOTAL_C = ACTIVE_COLUMNS + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL_C = ACTIVE_ROWS + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0]      HS_FIRST   = CNT_W'(ACTIVE_COLUMNS + H_FRONT);
    localparam logic [CNT_W-1:0]      HS_LAST    = CNT_W'(ACTIVE_COLUMNS + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0]      VS_FIRST   = CNT_W'(ACTIVE_ROWS + V_FRONT);
    localparam logic [CNT_W-1:0]      VS_LAST    = CNT_W'(ACTIVE_ROWS + V_FRONT + V_SYNC - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(32'd1);
    localparam logic                  LATENCY_OK = (READ_LATENCY < PIXEL_DIV);

    logic             tick_s;
    logic [CNT_W-1:0] h_count_s;
    logic [CNT_W-1:0] v_count_s;
    logic             active_s;
    logic             vblank_s;
    logic             frame_wrap_s;
    logic             wrap_pulse_s;
    logic             cursor_hit_s;
    logic             unused_s;
    rgb_t             pixel_s;

    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  hsync_r;
    logic                  vsync_r;
    logic                  video_on_r;
    rgb_t                  rgb_r;
    logic                  frame_start_r;

    vga_timing_gen #(
        .ACTIVE_COLUMNS (ACTIVE_COLUMNS),
        .ACTIVE_ROWS    (ACTIVE_ROWS),
        .H_TOTAL_P      (H_TOTAL_C),
        .V_TOTAL_P      (V_TOTAL_C),
        .PIXEL_DIV      (PIXEL_DIV)
    ) u_timing (
        .clk        (clk_i),
        .rst_n      (reset_ni),
        .tick       (tick_s),
        .h_count    (h_count_s),
        .v_count    (v_count_s),
        .active     (active_s),
        .vblank     (vblank_s),
        .frame_wrap (frame_wrap_s),
        .wrap_pulse (wrap_pulse_s)
    );

    // Raster address: counts active pixels and holds through blanking until the frame wraps.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            addr_r <= {ADDR_WIDTH{1'b0}};
        end else if (frame_wrap_s) begin
            addr_r <= {ADDR_WIDTH{1'b0}};
        end else if (tick_s && active_s) begin
            addr_r <= addr_r + ADDR_ONE;
        end else begin
            addr_r <= addr_r;
        end
    end

`ifdef CURSOR_OVERLAY_EN
    logic [CNT_W-1:0]        cursor_x_r;
    logic [CNT_W-1:0]        cursor_y_r;
    logic signed [CNT_W+1:0] dx_s;
    logic signed [CNT_W+1:0] dy_s;

    // Cursor is latched only at the frame wrap so a frame never shows two positions.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cursor_x_r <= {CNT_W{1'b1}};
            cursor_y_r <= {CNT_W{1'b1}};
        end else if (frame_wrap_s) begin
            cursor_x_r <= cursor_x_i;
            cursor_y_r <= cursor_y_i;
        end else begin
            cursor_x_r <= cursor_x_r;
            cursor_y_r <= cursor_y_r;
        end
    end

    // 5x5 block around the latched cursor position.
    always_comb begin
        dx_s         = $signed({2'b00, h_count_s}) - $signed({2'b00, cursor_x_r});
        dy_s         = $signed({2'b00, v_count_s}) - $signed({2'b00, cursor_y_r});
        cursor_hit_s = (dx_s >= -12'sd2) && (dx_s <= 12'sd2) &&
                       (dy_s >= -12'sd2) && (dy_s <= 12'sd2);
    end

    assign unused_s = ^{vram_read_data_i, LATENCY_OK};
`else
    assign cursor_hit_s = 1'b0;
    assign unused_s     = ^{vram_read_data_i, cursor_x_i, cursor_y_i, LATENCY_OK};
`endif

    // Colour of the stage-0 pixel from the returned VRAM cell.
    always_comb begin
        pixel_s = EMPTY_RGB;
        if (!active_s) begin
            pixel_s = EMPTY_RGB;
        end else if (cursor_hit_s) begin
            pixel_s = CURSOR_RGB;
        end else if (vram_read_data_i[0]) begin
            pixel_s = SAND_RGB;
        end else begin
            pixel_s = EMPTY_RGB;
        end
    end

    // Output stage: syncs, video_on and colour all lag the address by one pixel period.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            hsync_r       <= 1'b1;
            vsync_r       <= 1'b1;
            video_on_r    <= 1'b0;
            rgb_r         <= EMPTY_RGB;
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= wrap_pulse_s;
            if (tick_s) begin
                hsync_r    <= !in_window(h_count_s, HS_FIRST, HS_LAST);
                vsync_r    <= !in_window(v_count_s, VS_FIRST, VS_LAST);
                video_on_r <= active_s;
                rgb_r      <= pixel_s;
            end else begin
                hsync_r    <= hsync_r;
                vsync_r    <= vsync_r;
                video_on_r <= video_on_r;
                rgb_r      <= rgb_r;
            end
        end
    end

    assign vram_read_address_o = addr_r;
    assign hsync_o             = hsync_r;
    assign vsync_o             = vsync_r;
    assign video_on_o          = video_on_r;
    assign rgb_o               = rgb_r;
    assign frame_start_o       = frame_start_r;
    assign vblank_o            = vblank_s;

endmodule
